// File: rtl/sub_nbit_serial.sv
// sub_nbit_serial -- multi-cycle add/subtract unit, CHUNK bits per clock.
//
// Operands are latched on an in_valid/in_ready handshake, then processed
// LSB chunk first. The carry between chunks lives in a register. Once the
// final chunk is written, the result is held under out_valid until the
// consumer takes it with out_ready. Only one transaction is in flight.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits computed per clock; N = WIDTH/CHUNK cycles per operation
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   operands valid            in_ready  unit idle, can accept
//   A, B       unsigned operands         op_sub    1: A-B, 0: A+B
//   out_valid  result valid              out_ready consumer accepts result
//   D          result mod 2^WIDTH
//   B_out      sub: borrow (A < B); add: carry out of MSB
//   V          (only with SUB_OVERFLOW_EN) two's-complement overflow
//
// Optional feature macro: SUB_OVERFLOW_EN adds port V.

module sub_nbit_serial_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);
  logic [CHUNK:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum  = w_full[CHUNK-1:0];
  assign o_cout = w_full[CHUNK];
endmodule

module sub_nbit_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             B_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             V
`endif
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // already complemented for subtract
  logic             r_sub;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign D         = r_d;
  assign B_out     = r_bout;

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_k == KW'(N - 1));
  assign w_a_chunk = r_a[r_k*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_k*CHUNK +: CHUNK];

  sub_nbit_serial_chunk_add #(.CHUNK(CHUNK)) u_add (
    .i_a    (w_a_chunk),
    .i_b    (w_b_chunk),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next = S_BUSY;
      S_BUSY:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. Subtract is A + ~B + 1: the +1 enters as the initial carry,
  // so the complement covers the full width and no carry is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_d     <= '0;
      r_bout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a     <= A;
          r_b     <= op_sub ? ~B : B;
          r_sub   <= op_sub;
          r_carry <= op_sub;
          r_k     <= '0;
        end
        S_BUSY: begin
          r_d[r_k*CHUNK +: CHUNK] <= w_sum;
          r_carry                 <= w_cout;
          if (w_last) begin
            r_k    <= '0;
            // carry out of A + ~B + 1 is set exactly when no borrow occurred
            r_bout <= r_sub ? ~w_cout : w_cout;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic r_v;
  logic w_cmsb;

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
  assign w_cmsb = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
  assign V      = r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_v <= 1'b0;
    else if (r_state == S_BUSY && w_last) r_v <= w_cmsb ^ w_cout;
  end
`endif

endmodule

// File: tb/tb_sub_nbit_serial.sv
module tb_sub_nbit_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;

  // 8-bit, two chunks
  logic        in_valid = 1'b0, out_ready = 1'b0, op_sub = 1'b0;
  logic        in_ready, out_valid, B_out;
  logic [7:0]  A = '0, B = '0, D;
  // 16-bit, four chunks
  logic        in_valid2 = 1'b0, out_ready2 = 1'b1, op_sub2 = 1'b0;
  logic        in_ready2, out_valid2, B_out2;
  logic [15:0] A2 = '0, B2 = '0, D2;
`ifdef SUB_OVERFLOW_EN
  logic        V, V2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sub_nbit_serial #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .D(D), .B_out(B_out)
`ifdef SUB_OVERFLOW_EN
    , .V(V)
`endif
  );

  sub_nbit_serial #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .A(A2), .B(B2), .op_sub(op_sub2), .out_valid(out_valid2),
    .out_ready(out_ready2), .D(D2), .B_out(B_out2)
`ifdef SUB_OVERFLOW_EN
    , .V(V2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 8-bit unit with out_ready held high.
  task automatic run1(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic [7:0] ed, input logic eb);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin step(); guard++; end
    check({tag, "_rdy"}, in_ready, 1);
    A = a; B = b; op_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin step(); lat++; end
    check({tag, "_lat"}, lat, 2);
    check({tag, "_D"}, D, ed);
    check({tag, "_Bout"}, B_out, eb);
    step();
    check({tag, "_ovl_clr"}, out_valid, 0);
    check({tag, "_rdy_after"}, in_ready, 1);
  endtask

  // One full transaction on the 16-bit unit.
  task automatic run2(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic [15:0] ed, input logic eb,
                      input logic ev);
    int lat;
    A2 = a; B2 = b; op_sub2 = sub; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin step(); lat++; end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_D"}, D2, ed);
    check({tag, "_Bout"}, B_out2, eb);
`ifdef SUB_OVERFLOW_EN
    check({tag, "_V"}, V2, ev);
`else
    if (ev === 1'bx) check({tag, "_ev"}, 0, 1);
`endif
    step();
    check({tag, "_rdy_after"}, in_ready2, 1);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    step(); step();
    check("rst_rdy", in_ready, 1);
    check("rst_ovl", out_valid, 0);
    check("rst_D", D, 0);
    check("rst_Bout", B_out, 0);
    check("rst_rdy2", in_ready2, 1);
    check("rst_ovl2", out_valid2, 0);
    rst = 1'b0;
    step();

    // basic subtract, borrow cases, add with carry
    run1("t1_sub", 8'h50, 8'h20, 1'b1, 8'h30, 1'b0);
    run1("t2_0m1", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b1);
    run1("t2_Bzero", 8'h37, 8'h00, 1'b1, 8'h37, 1'b0);
    run1("t3_addc", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run1("t3_add", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    run1("t3_eq", 8'h80, 8'h80, 1'b1, 8'h00, 1'b0);

    // backpressure: hold result, ignore new operands while DONE
    A = 8'hA5; B = 8'hA5; op_sub = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    step();
    A = 8'h01; B = 8'h00; op_sub = 1'b0;   // in_valid stays high
    step(); step();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_ovl", out_valid, 1);
      check("t4_hold_D", D, 8'h00);
      check("t4_hold_Bout", B_out, 0);
      check("t4_hold_rdy", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();   // handshake; in_valid high the same cycle must not be taken
    check("t4_hs_ovl", out_valid, 0);
    check("t4_hs_rdy", in_ready, 1);
    step();   // now accepted from IDLE
    check("t4_acc", in_ready, 0);
    in_valid = 1'b0;
    step(); step();
    check("t4_next_ovl", out_valid, 1);
    check("t4_next_D", D, 8'h01);
    check("t4_next_Bout", B_out, 0);
    step();
    check("t4_idle", in_ready, 1);

    // reset mid-operation
    A = 8'hF0; B = 8'h0F; op_sub = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("t5_ovl", out_valid, 0);
    check("t5_D", D, 0);
    check("t5_Bout", B_out, 0);
    check("t5_rdy", in_ready, 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_stale", out_valid, 0);
    end
    run1("t5_recover", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b1);

    // 16-bit, four chunks; carry ripples through every chunk
    run2("t6_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    run2("t6_small", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0);
    run2("t6_addovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run2("t6_borrow", 16'h0100, 16'h0101, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
